// File: rtl/data_memory_be.sv
// data_memory_be: single-port data memory with byte-lane writes, selectable read latency
// and an optional zero-fill sequence after reset.
module data_memory_be #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int READ_LATENCY   = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    write_enable,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   write_data,
   input  logic [DATA_WIDTH/8-1:0] byte_en,
   output logic [DATA_WIDTH-1:0]   read_data,
   output logic                    read_valid,
   output logic                    busy
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int NB    = DATA_WIDTH/8;
   typedef enum logic {CLEAR, READY} state_t;
   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  rd_acc, wr_acc;
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR_ON_RESET != 0 ? CLEAR : READY;
         clr_cnt <= '0;
      end else begin
         state   <= state_nx;
         clr_cnt <= state == CLEAR ? clr_cnt + 1'b1 : clr_cnt;
      end
   end
   always_comb begin
      state_nx  = state == CLEAR && &clr_cnt ? READY : state;
      req_ready = ~rst & (state == READY);
      busy      = rst ? CLEAR_ON_RESET != 0 : state == CLEAR;
      rd_acc    = req_valid & req_ready & ~write_enable;
      wr_acc    = req_valid & req_ready & write_enable;
   end
   // the clear owns the array while it runs; requests cannot be accepted then anyway
   always_ff @(posedge clk) begin
      if (!rst && state == CLEAR) mem[clr_cnt] <= '0;
      else if (wr_acc)
         for (int i = 0; i < NB; i++)
            if (byte_en[i]) mem[addr][8*i +: 8] <= write_data[8*i +: 8];
   end
   generate
      if (READ_LATENCY == 0) begin : g_comb
         assign read_data  = mem[addr];
         assign read_valid = rd_acc;
      end else begin : g_reg
         always_ff @(posedge clk) begin
            if (rst) begin
               read_data  <= '0;
               read_valid <= 1'b0;
            end else begin
               read_valid <= rd_acc;
               if (rd_acc) read_data <= mem[addr];
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_data_memory_be.sv
// tb_data_memory_be: two configurations (cleared/combinational and persistent/registered)
// checked every cycle against an array model, plus hand-computed directed expectations.
module tb_data_memory_be;
   logic        tb_clk;
   logic        a_rst, a_valid, a_we, a_ready, a_rv, a_busy;
   logic [3:0]  a_addr, a_be;
   logic [31:0] a_wd, a_rd;
   logic        b_rst, b_valid, b_we, b_ready, b_rv, b_busy;
   logic [9:0]  b_addr;
   logic [3:0]  b_be;
   logic [31:0] b_wd, b_rd;

   data_memory_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(0), .CLEAR_ON_RESET(1)) u_a (
      .clk(tb_clk), .rst(a_rst), .req_valid(a_valid), .req_ready(a_ready), .write_enable(a_we),
      .addr(a_addr), .write_data(a_wd), .byte_en(a_be), .read_data(a_rd), .read_valid(a_rv),
      .busy(a_busy));
   data_memory_be #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(1), .CLEAR_ON_RESET(0)) u_b (
      .clk(tb_clk), .rst(b_rst), .req_valid(b_valid), .req_ready(b_ready), .write_enable(b_we),
      .addr(b_addr), .write_data(b_wd), .byte_en(b_be), .read_data(b_rd), .read_valid(b_rv),
      .busy(b_busy));

   initial tb_clk = 0;
   always #5 tb_clk = ~tb_clk;

   int passes = 0, total = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   // model A: contents become all-zero once 16 clean cycles follow a reset
   logic [31:0] ma [16];
   int          a_left = 0;
   bit          a_up = 0;
   always @(posedge tb_clk) begin
      if (a_up && !a_rst && a_left == 0 && a_valid && a_we)
         ma[a_addr] = (ma[a_addr] & ~lane_mask(a_be)) | (a_wd & lane_mask(a_be));
      if (a_rst) begin
         a_left = 16;
         a_up   = 1;
      end else if (a_left > 0) begin
         a_left--;
         if (a_left == 0) foreach (ma[i]) ma[i] = 0;
      end
   end

   // model B: contents persist; reads appear one cycle after acceptance
   logic [31:0] mb [1024];
   logic [31:0] b_rdq = 0;
   bit          b_rvq = 0, b_up = 0;
   always @(posedge tb_clk) begin
      bit acc;
      acc = b_up && !b_rst && b_valid;
      if (b_rst) begin
         b_rvq = 0;
         b_rdq = 0;
         b_up  = 1;
      end else begin
         b_rvq = acc && !b_we;
         if (b_rvq) b_rdq = mb[b_addr];
         if (acc && b_we) mb[b_addr] = (mb[b_addr] & ~lane_mask(b_be)) | (b_wd & lane_mask(b_be));
      end
   end

   always @(negedge tb_clk) begin
      if (a_up) begin
         chk("a_ready", {31'b0, a_ready}, {31'b0, !a_rst && a_left == 0});
         chk("a_busy", {31'b0, a_busy}, {31'b0, a_rst || a_left > 0});
         if (!a_rst && a_left == 0) begin
            chk("a_rvalid", {31'b0, a_rv}, {31'b0, a_valid && !a_we});
            chk("a_rdata", a_rd, ma[a_addr]);
         end else chk("a_rvalid_idle", {31'b0, a_rv}, 0);
      end
      if (b_up) begin
         chk("b_ready", {31'b0, b_ready}, {31'b0, !b_rst});
         chk("b_busy", {31'b0, b_busy}, 0);
         chk("b_rvalid", {31'b0, b_rv}, {31'b0, b_rvq});
         chk("b_rdata", b_rd, b_rdq);
      end
   end

   task automatic tick;
      @(posedge tb_clk);
      #1;
   endtask
   task automatic a_op(input logic v, w, input logic [3:0] ad, input logic [31:0] d, input logic [3:0] be);
      a_valid = v; a_we = w; a_addr = ad; a_wd = d; a_be = be;
   endtask
   task automatic b_op(input logic v, w, input logic [9:0] ad, input logic [31:0] d, input logic [3:0] be);
      b_valid = v; b_we = w; b_addr = ad; b_wd = d; b_be = be;
   endtask
   // counts busy cycles from the current cycle; drops any request after two of them
   task automatic a_clear_len(output int n);
      n = 0;
      @(negedge tb_clk);
      while (a_busy === 1'b1 && n < 40) begin
         n++;
         if (n >= 2) a_valid = 0;
         @(negedge tb_clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      a_rst = 1; b_rst = 1;
      a_op(0, 0, 0, 0, 0);
      b_op(0, 0, 0, 0, 0);
      tick;
      a_rst = 0; b_rst = 0;
      a_clear_len(n);
      chk("first_clear_len", n, 16);
      tick;
      // clear wipes earlier data; requests during the clear are dropped
      a_op(1, 1, 3, 32'hDEADBEEF, 4'hF); tick;
      a_op(0, 0, 0, 0, 0); a_rst = 1; tick;
      a_rst = 0; a_op(1, 1, 5, 32'h55, 4'hF);
      a_clear_len(n);
      chk("clear_len", n, 16);
      chk("ready_after_clear", {31'b0, a_ready}, 1);
      tick;
      a_op(1, 0, 3, 0, 0);
      @(negedge tb_clk); chk("read3_cleared", a_rd, 0); chk("read3_same_cycle_valid", {31'b0, a_rv}, 1);
      tick;
      a_op(1, 0, 5, 0, 0);
      @(negedge tb_clk); chk("read5_ignored_write", a_rd, 0);
      tick;
      // byte lanes
      a_op(1, 1, 10, 32'hAAAAAAAA, 4'hF); tick;
      a_op(1, 1, 10, 32'h11223344, 4'h5); tick;
      a_op(1, 1, 10, 32'hFFFFFFFF, 4'h0); tick;
      a_op(1, 0, 10, 0, 0);
      @(negedge tb_clk); chk("byte_lanes", a_rd, 32'hAA22AA44);
      tick;
      // combinational read-first on a write cycle
      a_op(1, 1, 4, 15, 4'hF); tick;
      a_op(1, 1, 4, 7, 4'hF);
      @(negedge tb_clk); chk("a_old_word_during_write", a_rd, 15); chk("a_no_rvalid_on_write", {31'b0, a_rv}, 0);
      tick;
      a_op(1, 0, 4, 0, 0);
      @(negedge tb_clk); chk("a_new_word", a_rd, 7);
      tick;
      // reset at clear cycle 7 restarts the whole clear
      a_op(0, 0, 0, 0, 0); a_rst = 1; tick;
      a_rst = 0;
      repeat (7) tick;
      a_rst = 1; tick;
      a_rst = 0;
      a_clear_len(n);
      chk("restarted_clear_len", n, 16);
      tick;
      a_op(1, 0, 10, 0, 0);
      @(negedge tb_clk); chk("byte_word_cleared", a_rd, 0);
      tick;
      a_op(0, 0, 0, 0, 0);

      // registered configuration: read-first collision
      b_op(1, 1, 20, 15, 4'hF); tick;
      b_op(1, 0, 20, 0, 0);
      @(negedge tb_clk); chk("b_no_same_cycle_valid", {31'b0, b_rv}, 0);
      tick;
      b_op(1, 1, 20, 7, 4'hF);
      @(negedge tb_clk); chk("b_old_word", b_rd, 15); chk("b_rvalid_next", {31'b0, b_rv}, 1);
      tick;
      b_op(1, 0, 20, 0, 0);
      @(negedge tb_clk); chk("b_hold", b_rd, 15); chk("b_rvalid_drop", {31'b0, b_rv}, 0);
      tick;
      b_op(0, 0, 0, 0, 0);
      @(negedge tb_clk); chk("b_new_word", b_rd, 7);
      tick;
      // back-to-back reads
      for (int i = 1; i <= 3; i++) begin
         b_op(1, 1, 10'(i), i, 4'hF); tick;
      end
      for (int i = 1; i <= 3; i++) begin
         b_op(1, 0, 10'(i), 0, 0); tick;
         @(negedge tb_clk); chk("b2b_data", b_rd, i); chk("b2b_valid", {31'b0, b_rv}, 1);
      end
      b_op(0, 0, 0, 0, 0); tick;
      @(negedge tb_clk); chk("b2b_end", {31'b0, b_rv}, 0);
      // persistence across reset; request during reset ignored
      b_op(1, 1, 500, 32'hBBBBBBBB, 4'hF); tick;
      b_op(1, 1, 500, 32'h12345678, 4'hF); b_rst = 1;
      @(negedge tb_clk); chk("b_ready_in_reset", {31'b0, b_ready}, 0);
      tick;
      b_rst = 0; b_op(1, 0, 500, 0, 0);
      @(negedge tb_clk); chk("b_ready_after_reset", {31'b0, b_ready}, 1); chk("b_rdata_reset", b_rd, 0);
      tick;
      b_op(0, 0, 0, 0, 0);
      @(negedge tb_clk); chk("b_persist", b_rd, 32'hBBBBBBBB);
      tick;
      tick;
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
